// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the SRAM bus arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {
        ST_CPU    = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// Saturating wait counter with synchronous clear.
// term reports that the pending DMA request has waited long enough.
module mem_arb_wait_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic term
);

    localparam logic [WAIT_W-1:0] TERM_VAL = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Clear wins over increment; the count sticks at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != TERM_VAL)) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == TERM_VAL);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one asynchronous SRAM between the CPU (default owner, pass-through)
// and a DMA master that steals the bus for a fixed-length access.
//
// state  | meaning
// -------+-------------------------------------------------------------
// CPU    | CPU owns the bus, mem_* follow the CPU pins
// SETUP  | DMA address/data driven, both strobes high
// STROBE | DMA strobe low for STROBE_CYCLES cycles, read data captured last
// DONE   | strobes high, address held, dma_ack pulses
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STROBE_CYCLES = 1,
    parameter int MAX_WAIT      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_n_oe,
    input  logic              cpu_n_we,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_n_rdy,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_a,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_n_oe,
    output logic              mem_n_we,
    output logic              mem_d_oe
);

    arb_state_t        state_q, state_d;
    logic [3:0]        strb_cnt_q, strb_cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              n_rdy_q, n_rdy_d;
    logic              wait_term;
    logic              grant;

    // A CPU write strobe is never cut; a busy CPU read is only preempted
    // once the request has waited out its budget.
    assign grant = (state_q == ST_CPU) && dma_req && cpu_n_we
                   && ((cpu_n_oe && cpu_n_we) || wait_term);

    mem_arb_wait_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  ((state_q == ST_CPU) && dma_req && !grant),
        .clr  (grant),
        .term (wait_term)
    );

    // Next-state, strobe down-counter and DMA read capture.
    // DONE always returns to CPU, so the CPU gets at least one owned cycle.
    always_comb begin
        state_d    = state_q;
        strb_cnt_d = strb_cnt_q;
        rdata_d    = rdata_q;
        case (state_q)
            ST_CPU: begin
                if (grant) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d    = ST_STROBE;
                strb_cnt_d = 4'(STROBE_CYCLES - 1);
            end
            ST_STROBE: begin
                if (strb_cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    if (!dma_we) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    strb_cnt_d = strb_cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_CPU;
            end
            default: begin
                state_d = ST_CPU;
            end
        endcase
        n_rdy_d = (state_d != ST_CPU);
    end

    // Control registers; reset aborts any DMA access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CPU;
            strb_cnt_q <= 4'd0;
            rdata_q    <= '0;
            n_rdy_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            strb_cnt_q <= strb_cnt_d;
            rdata_q    <= rdata_d;
            n_rdy_q    <= n_rdy_d;
        end
    end

    // Bus mux: CPU pass-through, or DMA address/data with a strobe only in STROBE.
    // Data stays driven through DONE so the write strobe rises with data valid.
    always_comb begin
        mem_a     = cpu_a;
        mem_wdata = cpu_wdata;
        mem_n_oe  = cpu_n_oe;
        mem_n_we  = cpu_n_we;
        mem_d_oe  = ~cpu_n_we;
        dma_ack   = 1'b0;
        if (state_q != ST_CPU) begin
            mem_a     = dma_a;
            mem_wdata = dma_wdata;
            mem_n_oe  = 1'b1;
            mem_n_we  = 1'b1;
            mem_d_oe  = dma_we;
            if (state_q == ST_STROBE) begin
                mem_n_oe = dma_we;
                mem_n_we = ~dma_we;
            end
            if (state_q == ST_DONE) begin
                dma_ack = 1'b1;
            end
        end
    end

    assign cpu_rdata = mem_rdata;
    assign cpu_n_rdy = n_rdy_q;
    assign dma_rdata = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (strobe length 1 and 2), each on
// its own SRAM model, checked every cycle against an access-position model.
module tb_mem_bus_arbiter;

    localparam int MAXW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] cpu_a     [2];
    logic [7:0]  cpu_wdata [2];
    logic        cpu_n_oe  [2];
    logic        cpu_n_we  [2];
    logic        dma_req   [2];
    logic        dma_we    [2];
    logic [15:0] dma_a     [2];
    logic [7:0]  dma_wdata [2];

    logic [15:0] mem_a     [2];
    logic [7:0]  mem_wdata [2];
    logic [7:0]  mem_rdata [2];
    logic [7:0]  cpu_rdata [2];
    logic [7:0]  dma_rdata [2];
    logic        mem_n_oe  [2];
    logic        mem_n_we  [2];
    logic        mem_d_oe  [2];
    logic        cpu_n_rdy [2];
    logic        dma_ack   [2];

    int checks = 0;
    int errors = 0;

    // SRAM contents are stored XORed with a fixed address pattern, so the
    // power-up image is fpat(a); fpat(0x1234) = 0x5A.
    bit [7:0] ram0 [0:65535];
    bit [7:0] ram1 [0:65535];

    function automatic logic [7:0] fpat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h7C;
    endfunction

    function automatic logic [7:0] rd(input int k, input logic [15:0] a);
        return ((k == 0) ? ram0[a] : ram1[a]) ^ fpat(a);
    endfunction

    assign mem_rdata[0] = ram0[mem_a[0]] ^ fpat(mem_a[0]);
    assign mem_rdata[1] = ram1[mem_a[1]] ^ fpat(mem_a[1]);

    always @(posedge clk) begin
        if (!mem_n_we[0] && mem_d_oe[0]) ram0[mem_a[0]] <= mem_wdata[0] ^ fpat(mem_a[0]);
        if (!mem_n_we[1] && mem_d_oe[1]) ram1[mem_a[1]] <= mem_wdata[1] ^ fpat(mem_a[1]);
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_bus_arbiter #(
            .STROBE_CYCLES (g + 1),
            .MAX_WAIT      (MAXW)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cpu_a     (cpu_a[g]),
            .cpu_wdata (cpu_wdata[g]),
            .cpu_n_oe  (cpu_n_oe[g]),
            .cpu_n_we  (cpu_n_we[g]),
            .cpu_rdata (cpu_rdata[g]),
            .cpu_n_rdy (cpu_n_rdy[g]),
            .dma_req   (dma_req[g]),
            .dma_we    (dma_we[g]),
            .dma_a     (dma_a[g]),
            .dma_wdata (dma_wdata[g]),
            .dma_ack   (dma_ack[g]),
            .dma_rdata (dma_rdata[g]),
            .mem_a     (mem_a[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .mem_n_oe  (mem_n_oe[g]),
            .mem_n_we  (mem_n_we[g]),
            .mem_d_oe  (mem_d_oe[g])
        );
    end

    // Model: m_pos = -1 while the CPU owns the bus, otherwise the cycle
    // index inside a DMA access (0 setup, 1..S strobe, S+1 done).
    int         m_pos  [2] = '{-1, -1};
    int         m_wait [2] = '{0, 0};
    logic [7:0] m_rdata[2] = '{8'h00, 8'h00};

    always @(negedge clk) begin
        int         s_len;
        logic       strobing;
        logic [15:0] ea;
        logic [7:0] ew;
        logic       eoe, ewe, edoe;
        logic [44:0] got, expv;
        for (int k = 0; k < 2; k++) begin
            s_len = k + 1;
            if (rst) begin
                m_pos[k]   = -1;
                m_wait[k]  = 0;
                m_rdata[k] = 8'h00;
            end
            strobing = (m_pos[k] >= 1) && (m_pos[k] <= s_len);
            if (m_pos[k] < 0) begin
                ea = cpu_a[k]; ew = cpu_wdata[k];
                eoe = cpu_n_oe[k]; ewe = cpu_n_we[k]; edoe = !cpu_n_we[k];
            end else begin
                ea = dma_a[k]; ew = dma_wdata[k]; edoe = dma_we[k];
                eoe = strobing ? dma_we[k] : 1'b1;
                ewe = strobing ? !dma_we[k] : 1'b1;
            end
            expv = {ea, ew, eoe, ewe, edoe, (m_pos[k] >= 0), (m_pos[k] == s_len + 1),
                    m_rdata[k], rd(k, ea)};
            got  = {mem_a[k], mem_wdata[k], mem_n_oe[k], mem_n_we[k], mem_d_oe[k],
                    cpu_n_rdy[k], dma_ack[k], dma_rdata[k], cpu_rdata[k]};
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL model_cmp[%0d] t=%0t got %h exp %h", k, $time, got, expv);
            end
            if (!rst) begin
                if (m_pos[k] < 0) begin
                    if (dma_req[k] && cpu_n_we[k]
                        && ((cpu_n_oe[k] && cpu_n_we[k]) || m_wait[k] == MAXW - 1)) begin
                        m_pos[k]  = 0;
                        m_wait[k] = 0;
                    end else if (dma_req[k] && m_wait[k] < MAXW - 1) begin
                        m_wait[k]++;
                    end
                end else if (m_pos[k] == s_len + 1) begin
                    m_pos[k] = -1;
                end else begin
                    if (m_pos[k] == s_len && !dma_we[k]) m_rdata[k] = rd(k, dma_a[k]);
                    m_pos[k]++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, expv);
        end
    endtask

    // One DMA access with an idle CPU; returns latency and strobe/stall counts.
    task automatic dma_xfer(input int k, input logic we, input logic [15:0] a,
                            input logic [7:0] wd, output int lat, output int oe_lo,
                            output int we_lo, output int rdy_hi, output int a_bad);
        @(posedge clk); #1;
        dma_we[k] = we; dma_a[k] = a; dma_wdata[k] = wd; dma_req[k] = 1'b1;
        lat = 0; oe_lo = 0; we_lo = 0; rdy_hi = 0; a_bad = 0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (!mem_n_oe[k]) oe_lo++;
            if (!mem_n_we[k]) we_lo++;
            if (cpu_n_rdy[k]) begin
                rdy_hi++;
                if (mem_a[k] !== a) a_bad++;
            end
        end while (!dma_ack[k] && lat < 40);
        chk("dma_xfer_ack_seen", dma_ack[k], 1'b1);
        @(posedge clk); #1;
        dma_req[k] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, oe_lo, we_lo, rdy_hi, a_bad;
        int waitc, bad, cyc, hold, ackn;
        logic granted, acked, seen;
        logic [15:0] addr;
        logic [9:0]  pat;
        logic [7:0]  rd1;

        for (int k = 0; k < 2; k++) begin
            cpu_a[k] = 16'h0; cpu_wdata[k] = 8'h0; cpu_n_oe[k] = 1'b1; cpu_n_we[k] = 1'b1;
            dma_req[k] = 1'b0; dma_we[k] = 1'b0; dma_a[k] = 16'h0; dma_wdata[k] = 8'h0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_n_rdy", cpu_n_rdy[k], 1'b0);
            chk("rst_ack", dma_ack[k], 1'b0);
            chk("rst_rdata", dma_rdata[k], 8'h00);
            chk("rst_n_oe", mem_n_oe[k], 1'b1);
        end
        @(posedge clk); #1 rst = 1'b0;

        // Idle-CPU DMA read, S=1
        dma_xfer(0, 1'b0, 16'h1234, 8'h00, lat, oe_lo, we_lo, rdy_hi, a_bad);
        chk("rd_s1_latency", lat, 3);
        chk("rd_s1_oe_low", oe_lo, 1);
        chk("rd_s1_we_low", we_lo, 0);
        chk("rd_s1_nrdy_hi", rdy_hi, 3);
        chk("rd_s1_rdata", dma_rdata[0], 8'h5A);

        // DMA write, S=2
        dma_xfer(1, 1'b1, 16'h0100, 8'hC3, lat, oe_lo, we_lo, rdy_hi, a_bad);
        chk("wr_s2_latency", lat, 4);
        chk("wr_s2_we_low", we_lo, 2);
        chk("wr_s2_oe_low", oe_lo, 0);
        chk("wr_s2_addr_stable", a_bad, 0);
        chk("wr_s2_ram", rd(1, 16'h0100), 8'hC3);

        // DMA read, S=2 (also leaves nonzero dma_rdata for the reset test)
        dma_xfer(1, 1'b0, 16'h1234, 8'h00, lat, oe_lo, we_lo, rdy_hi, a_bad);
        chk("rd_s2_latency", lat, 4);
        chk("rd_s2_oe_low", oe_lo, 2);
        chk("rd_s2_rdata", dma_rdata[1], 8'h5A);

        // Busy CPU reading 0x0FF0..0x1000 with a held request
        addr = 16'h0FF0; waitc = 0; bad = 0; cyc = 0; granted = 1'b0; acked = 1'b0;
        @(posedge clk); #1;
        cpu_a[0] = addr; cpu_n_oe[0] = 1'b0;
        dma_we[0] = 1'b0; dma_a[0] = 16'h2222; dma_req[0] = 1'b1;
        while (addr != 16'h1001 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (!cpu_n_rdy[0]) begin
                if (cpu_rdata[0] !== rd(0, addr)) bad++;
                addr++;
                if (!granted) waitc++;
            end else begin
                granted = 1'b1;
            end
            if (dma_ack[0]) acked = 1'b1;
            @(posedge clk); #1;
            cpu_a[0] = addr;
            if (acked) dma_req[0] = 1'b0;
        end
        cpu_n_oe[0] = 1'b1; dma_req[0] = 1'b0;
        chk("busy_wait_cycles", waitc, MAXW);
        chk("busy_cpu_reads", bad, 0);
        chk("busy_reached_1000", addr, 16'h1001);
        chk("busy_dma_acked", acked, 1'b1);
        chk("busy_dma_rdata", dma_rdata[0], fpat(16'h2222));

        // Request during a CPU write strobe, wait counter saturated
        @(posedge clk); #1;
        cpu_a[0] = 16'h0200; cpu_wdata[0] = 8'h96; cpu_n_we[0] = 1'b0; cpu_n_oe[0] = 1'b1;
        dma_we[0] = 1'b0; dma_a[0] = 16'h3333; dma_req[0] = 1'b1;
        hold = 0;
        repeat (12) begin
            @(negedge clk);
            if (!cpu_n_rdy[0]) hold++;
        end
        @(posedge clk); #1;
        cpu_n_we[0] = 1'b1; cpu_n_oe[0] = 1'b0;
        @(negedge clk);
        chk("wrstb_no_grant_during_write", hold, 12);
        chk("wrstb_cpu_owns_after_write", cpu_n_rdy[0], 1'b0);
        chk("wrstb_readback", cpu_rdata[0], 8'h96);
        @(negedge clk);
        chk("wrstb_grant_next", cpu_n_rdy[0], 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (dma_ack[0]) seen = 1'b1;
        end
        chk("wrstb_ack", seen, 1'b1);
        @(posedge clk); #1;
        dma_req[0] = 1'b0; cpu_n_oe[0] = 1'b1;
        chk("wrstb_ram", rd(0, 16'h0200), 8'h96);

        // Back-to-back DMA reads, S=1
        repeat (2) @(posedge clk);
        #1;
        dma_we[0] = 1'b0; dma_a[0] = 16'h0400; dma_req[0] = 1'b1;
        ackn = 0; pat = '0; rd1 = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pat[i] = cpu_n_rdy[0];
            if (dma_ack[0]) begin
                ackn++;
                if (ackn == 1) rd1 = dma_rdata[0];
            end
            @(posedge clk); #1;
            if (ackn == 1) dma_a[0] = 16'h0401;
            if (ackn >= 2) dma_req[0] = 1'b0;
        end
        dma_req[0] = 1'b0;
        chk("b2b_nrdy_pattern", pat, 10'b0011101110);
        chk("b2b_first_rdata", rd1, 8'h78);
        chk("b2b_second_rdata", dma_rdata[0], 8'h79);

        // Reset during STROBE on the S=2 instance
        @(posedge clk); #1;
        dma_we[1] = 1'b0; dma_a[1] = 16'h0500; dma_req[1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (!mem_n_oe[1]) seen = 1'b1;
        end
        chk("rstmid_strobe_reached", seen, 1'b1);
        #2;
        rst = 1'b1; dma_req[1] = 1'b0;
        #1;
        chk("rstmid_oe_high", mem_n_oe[1], 1'b1);
        chk("rstmid_rdata_clr", dma_rdata[1], 8'h00);
        chk("rstmid_nrdy", cpu_n_rdy[1], 1'b0);
        chk("rstmid_ack", dma_ack[1], 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0; hold = 0;
        repeat (6) begin
            @(negedge clk);
            if (dma_ack[1]) seen = 1'b1;
            if (cpu_n_rdy[1]) hold++;
        end
        chk("rstmid_no_ack_after", seen, 1'b0);
        chk("rstmid_cpu_owns", hold, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
